// File: rtl/debug_slave_sysclk_queue_if.sv
// Bus bundle between the JTAG debug slave system-clock queue and its tck/OCI neighbours.
// parity_err exists only when DEBUG_SLAVE_PARITY_EN is defined.
interface debug_slave_sysclk_queue_if #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int QUEUE_DEPTH = 4
);
  logic [IR_WIDTH-1:0]          ir_in;
  logic [DR_WIDTH-1:0]          sr;
  logic                         vs_udr;
  logic                         vs_uir;
  logic                         cmd_ready;
  logic                         clr_err;
  logic                         cmd_valid;
  logic [IR_WIDTH-1:0]          cmd_ir;
  logic [DR_WIDTH-1:0]          jdo;
  logic [2**IR_WIDTH-1:0]       take_action;
  logic [2**IR_WIDTH-1:0]       take_no_action;
  logic                         ir_update;
  logic [$clog2(QUEUE_DEPTH):0] queue_count;
  logic                         overflow;
`ifdef DEBUG_SLAVE_PARITY_EN
  logic                         parity_err;

  modport master (
    output ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_err,
    input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
           ir_update, queue_count, overflow, parity_err
  );

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_err,
    output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
           ir_update, queue_count, overflow, parity_err
  );
`else
  modport master (
    output ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_err,
    input  cmd_valid, cmd_ir, jdo, take_action, take_no_action,
           ir_update, queue_count, overflow
  );

  modport slave (
    input  ir_in, sr, vs_udr, vs_uir, cmd_ready, clr_err,
    output cmd_valid, cmd_ir, jdo, take_action, take_no_action,
           ir_update, queue_count, overflow
  );
`endif
endinterface

// File: rtl/debug_slave_sysclk_queue.sv
// System-clock side of the JTAG debug slave: strobe synchronisers, command queue and one-hot dispatch.
// Optional sr[0] parity screening is enabled by defining DEBUG_SLAVE_PARITY_EN.
module debug_slave_sysclk_queue #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  debug_slave_sysclk_queue_if.slave   bus
);
  localparam int NCMD = 2**IR_WIDTH;
  localparam int AW   = $clog2(QUEUE_DEPTH);
  localparam int CW   = AW + 1;
  localparam int EW   = IR_WIDTH + DR_WIDTH;

  typedef logic [EW-1:0] entry_t;

`ifdef DEBUG_SLAVE_PARITY_EN
  // The check bit is the complement of the XOR over the payload bits above it.
  function automatic logic parity_ok(input logic [DR_WIDTH-1:0] d);
    return d[0] == ~(^d[DR_WIDTH-1:1]);
  endfunction
`endif

  logic [SYNC_STAGES-1:0] fill_q;
  logic [SYNC_STAGES-1:0] udr_sync_q;
  logic [SYNC_STAGES-1:0] uir_sync_q;
  logic                   udr_prev_q;
  logic                   uir_prev_q;
  logic                   udr_armed_q;
  logic                   uir_armed_q;
  logic                   udr_armed_d;
  logic                   uir_armed_d;
  logic                   ir_update_q;

  logic                   sync_valid_s;
  logic                   udr_level_s;
  logic                   uir_level_s;
  logic                   udr_rise_s;
  logic                   uir_rise_s;

  entry_t                 mem_q [QUEUE_DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q;
  logic [AW-1:0]          rd_ptr_d;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   cmd_valid_q;
  logic                   cmd_valid_d;
  logic [DR_WIDTH-1:0]    jdo_q;
  logic [DR_WIDTH-1:0]    jdo_d;
  logic [NCMD-1:0]        take_action_q;
  logic [NCMD-1:0]        take_action_d;
  logic [NCMD-1:0]        take_no_action_q;
  logic [NCMD-1:0]        take_no_action_d;
  logic                   overflow_q;
  logic                   overflow_d;

  entry_t                 head_s;
  entry_t                 wr_entry_s;
  logic [IR_WIDTH-1:0]    head_ir_s;
  logic [NCMD-1:0]        head_onehot_s;
  logic                   par_ok_s;
  logic                   push_req_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;

`ifdef DEBUG_SLAVE_PARITY_EN
  logic                   parity_err_q;
  logic                   parity_err_d;
`endif

  // Strobe detection: a level only arms once it has been observed low after the pipeline refilled.
  always_comb begin
    sync_valid_s = fill_q[SYNC_STAGES-1];
    udr_level_s  = udr_sync_q[SYNC_STAGES-1];
    uir_level_s  = uir_sync_q[SYNC_STAGES-1];
    udr_rise_s   = udr_level_s & ~udr_prev_q & udr_armed_q;
    uir_rise_s   = uir_level_s & ~uir_prev_q & uir_armed_q;
    udr_armed_d  = udr_armed_q | (sync_valid_s & ~udr_level_s);
    uir_armed_d  = uir_armed_q | (sync_valid_s & ~uir_level_s);
  end

  // Synchroniser chains, edge history, arm flags and the ir_update pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q      <= '0;
      udr_sync_q  <= '0;
      uir_sync_q  <= '0;
      udr_prev_q  <= 1'b0;
      uir_prev_q  <= 1'b0;
      udr_armed_q <= 1'b0;
      uir_armed_q <= 1'b0;
      ir_update_q <= 1'b0;
    end else begin
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      udr_sync_q  <= {udr_sync_q[SYNC_STAGES-2:0], bus.vs_udr};
      uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], bus.vs_uir};
      udr_prev_q  <= udr_level_s;
      uir_prev_q  <= uir_level_s;
      udr_armed_q <= udr_armed_d;
      uir_armed_q <= uir_armed_d;
      ir_update_q <= uir_rise_s;
    end
  end

  // Queue control, dispatch decode and sticky error next-state
  always_comb begin
    head_s        = mem_q[rd_ptr_q];
    head_ir_s     = head_s[EW-1:DR_WIDTH];
    head_onehot_s = '0;
    head_onehot_s[head_ir_s] = 1'b1;
    wr_entry_s    = {bus.ir_in, bus.sr};
`ifdef DEBUG_SLAVE_PARITY_EN
    par_ok_s      = parity_ok(bus.sr);
    parity_err_d  = (udr_rise_s & ~par_ok_s) | (parity_err_q & ~bus.clr_err);
`else
    par_ok_s      = 1'b1;
`endif
    push_req_s    = udr_rise_s & par_ok_s;
    full_s        = (count_q == CW'(QUEUE_DEPTH));
    pop_s         = cmd_valid_q & bus.cmd_ready;
    push_s        = push_req_s & (~full_s | pop_s);
    drop_s        = push_req_s & full_s & ~pop_s;
    overflow_d    = drop_s | (overflow_q & ~bus.clr_err);

    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cmd_valid_d = (count_d != CW'(0));

    // Dispatch pulses last exactly one cycle because they default to zero.
    jdo_d            = jdo_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    if (pop_s) begin
      jdo_d = head_s[DR_WIDTH-1:0];
      if (head_s[DR_WIDTH-1]) begin
        take_action_d = head_onehot_s;
      end else begin
        take_no_action_d = head_onehot_s;
      end
    end else begin
      jdo_d = jdo_q;
    end
  end

  // Queue storage, pointers, dispatch registers and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      cmd_valid_q      <= 1'b0;
      jdo_q            <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overflow_q       <= 1'b0;
`ifdef DEBUG_SLAVE_PARITY_EN
      parity_err_q     <= 1'b0;
`endif
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wr_entry_s;
      end
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      cmd_valid_q      <= cmd_valid_d;
      jdo_q            <= jdo_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overflow_q       <= overflow_d;
`ifdef DEBUG_SLAVE_PARITY_EN
      parity_err_q     <= parity_err_d;
`endif
    end
  end

  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_ir         = head_ir_s;
  assign bus.jdo            = jdo_q;
  assign bus.take_action    = take_action_q;
  assign bus.take_no_action = take_no_action_q;
  assign bus.ir_update      = ir_update_q;
  assign bus.queue_count    = count_q;
  assign bus.overflow       = overflow_q;
`ifdef DEBUG_SLAVE_PARITY_EN
  assign bus.parity_err     = parity_err_q;
`endif

endmodule

// File: tb/tb_debug_slave_sysclk_queue.sv
// Directed bench for debug_slave_sysclk_queue: capture latency, dispatch, overflow, push/pop collision, arming.
module tb_debug_slave_sysclk_queue;
  localparam int DRW = 38;
  localparam int IRW = 2;
  localparam int SS  = 2;
  localparam int QD  = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  debug_slave_sysclk_queue_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .QUEUE_DEPTH(QD)) bus ();

  debug_slave_sysclk_queue #(
    .DR_WIDTH(DRW), .IR_WIDTH(IRW), .SYNC_STAGES(SS), .QUEUE_DEPTH(QD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // With parity screening built in, payloads carry a valid check bit in sr[0].
  function automatic logic [DRW-1:0] mk_sr(input logic [DRW-1:0] v);
    logic [DRW-1:0] r;
    r = v;
`ifdef DEBUG_SLAVE_PARITY_EN
    r[0] = ~(^r[DRW-1:1]);
`endif
    return r;
  endfunction

  task automatic do_update(input logic [IRW-1:0] ir, input logic [DRW-1:0] s);
    bus.ir_in  = ir;
    bus.sr     = s;
    bus.vs_udr = 1'b1;
    tick(3);
    bus.vs_udr = 1'b0;
    tick(4);
  endtask

  task automatic count_uir_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (bus.ir_update) pulses++;
    end
  endtask

  initial begin
    logic [DRW-1:0] s1;
    logic [DRW-1:0] snew;
    int             pulses;

    reset         = 1'b1;
    bus.ir_in     = '0;
    bus.sr        = '0;
    bus.vs_udr    = 1'b0;
    bus.vs_uir    = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.clr_err   = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("rst_count", 64'(bus.queue_count), 64'd0);
    check("rst_jdo", 64'(bus.jdo), 64'd0);
    check("rst_take", 64'({bus.take_action, bus.take_no_action}), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    check("rst_irupd", 64'(bus.ir_update), 64'd0);
`ifdef DEBUG_SLAVE_PARITY_EN
    check("rst_perr", 64'(bus.parity_err), 64'd0);
`endif
    tick(5);

    // Capture latency: valid only after the third edge sampling vs_udr high.
    s1         = mk_sr(38'h20_0000_0001);
    bus.ir_in  = 2'd2;
    bus.sr     = s1;
    bus.vs_udr = 1'b1;
    tick(1);
    check("lat_e1", 64'(bus.cmd_valid), 64'd0);
    tick(1);
    check("lat_e2", 64'(bus.cmd_valid), 64'd0);
    tick(1);
    check("lat_e3", 64'(bus.cmd_valid), 64'd1);
    check("lat_ir", 64'(bus.cmd_ir), 64'd2);
    check("lat_cnt", 64'(bus.queue_count), 64'd1);
    bus.vs_udr = 1'b0;
    tick(4);
    check("hold_cnt", 64'(bus.queue_count), 64'd1);

    // Pop of an action entry.
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    check("pop_jdo", 64'(bus.jdo), 64'(s1));
    check("pop_act", 64'(bus.take_action), 64'h4);
    check("pop_noact", 64'(bus.take_no_action), 64'h0);
    check("pop_cnt", 64'(bus.queue_count), 64'd0);
    check("pop_valid", 64'(bus.cmd_valid), 64'd0);
    tick(1);
    check("pulse_end", 64'(bus.take_action), 64'h0);
    check("jdo_hold", 64'(bus.jdo), 64'(s1));

    // Five updates into a four-deep queue.
    for (int i = 0; i < 5; i++) begin
      do_update(IRW'(i % 4), mk_sr(38'h100 + 38'(i * 2)));
    end
    check("full_cnt", 64'(bus.queue_count), 64'd4);
    check("full_ovf", 64'(bus.overflow), 64'd1);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("drain_noact", 64'(bus.take_no_action), 64'(4'b0001 << i));
      check("drain_jdo", 64'(bus.jdo), 64'(mk_sr(38'h100 + 38'(i * 2))));
    end
    bus.cmd_ready = 1'b0;
    check("drain_empty", 64'(bus.cmd_valid), 64'd0);
    tick(1);
    check("drain_cnt", 64'(bus.queue_count), 64'd0);
    check("drain_quiet", 64'(bus.take_no_action), 64'h0);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("clr_ovf", 64'(bus.overflow), 64'd0);

    // Full queue with a push landing on the same edge as a pop.
    for (int i = 0; i < 4; i++) begin
      do_update(IRW'(i), mk_sr(38'h200 + 38'(i * 4)));
    end
    check("refill_cnt", 64'(bus.queue_count), 64'd4);
    snew       = mk_sr(38'h2A);
    bus.ir_in  = 2'd1;
    bus.sr     = snew;
    bus.vs_udr = 1'b1;
    tick(2);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    check("coll_cnt", 64'(bus.queue_count), 64'd4);
    check("coll_ovf", 64'(bus.overflow), 64'd0);
    check("coll_noact", 64'(bus.take_no_action), 64'h1);
    check("coll_jdo", 64'(bus.jdo), 64'(mk_sr(38'h200)));
    bus.vs_udr = 1'b0;
    tick(4);
    bus.cmd_ready = 1'b1;
    tick(4);
    bus.cmd_ready = 1'b0;
    check("coll_last_noact", 64'(bus.take_no_action), 64'h2);
    check("coll_last_jdo", 64'(bus.jdo), 64'(snew));
    check("coll_last_cnt", 64'(bus.queue_count), 64'd0);

    // Reset mid-operation with both levels held high through release.
    do_update(2'd3, mk_sr(38'h55));
    check("pre_rst_cnt", 64'(bus.queue_count), 64'd1);
    bus.vs_udr = 1'b1;
    bus.vs_uir = 1'b1;
    reset      = 1'b1;
    tick(2);
    reset = 1'b0;
    count_uir_pulses(6, pulses);
    check("hi_rst_cnt", 64'(bus.queue_count), 64'd0);
    check("hi_rst_valid", 64'(bus.cmd_valid), 64'd0);
    check("hi_rst_irupd", 64'(pulses), 64'd0);
    bus.vs_udr = 1'b0;
    bus.vs_uir = 1'b0;
    tick(4);
    do_update(2'd1, mk_sr(38'h66));
    check("rearm_cnt", 64'(bus.queue_count), 64'd1);
    bus.vs_uir = 1'b1;
    count_uir_pulses(8, pulses);
    check("irupd_pulses", 64'(pulses), 64'd1);
    check("irupd_cnt", 64'(bus.queue_count), 64'd1);
    bus.vs_uir = 1'b0;
    tick(4);

`ifdef DEBUG_SLAVE_PARITY_EN
    do_update(2'd0, 38'h00_0000_0003);
    check("par_bad_cnt", 64'(bus.queue_count), 64'd1);
    check("par_err", 64'(bus.parity_err), 64'd1);
    check("par_no_ovf", 64'(bus.overflow), 64'd0);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("par_clr", 64'(bus.parity_err), 64'd0);
    do_update(2'd0, 38'h00_0000_0002);
    check("par_good_cnt", 64'(bus.queue_count), 64'd2);
    check("par_good_err", 64'(bus.parity_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
